// File: rtl/display_pkg.sv
// display_pkg: shared FSM state encoding and bit-plane on-time function for the BCM panel driver.
// Contents:
//   state_t        - driver sequencer states
//   plane_on_time  - lit cycles for a bit plane: brightness * 2^plane
package display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT_LO,
        SHIFT_HI,
        WAIT_LAT,
        LATCH,
        FRAME_END
    } state_t;

    localparam int ON_TIME_W = 32;

    function automatic logic [ON_TIME_W-1:0] plane_on_time(input logic [7:0] brightness, input int unsigned plane);
        return {{(ON_TIME_W-8){1'b0}}, brightness} << plane;
    endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// bcm_on_timer: output-enable down-counter for binary-coded modulation.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_load    - load i_value this cycle (takes priority over counting)
//   i_value   - on-time in cycles
//   o_zero    - counter is zero (panel dark)
module bcm_on_timer #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [width-1:0] i_value,
    output logic             o_zero
);

    logic [width-1:0] r_count;

    assign o_zero = r_count == '0;

    // Counts down every cycle it is non-zero, i.e. every cycle the panel is lit.
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (!o_zero)
            r_count <= r_count - width'(1);
    end

endmodule

// File: rtl/display_driver_bcm.sv
// display_driver_bcm: LED panel driver sequencing fetch, shift, latch and BCM output enable.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   brightness           - global on-time multiplier, sampled at each lat pulse
//   flip_req / flip_ack  - new frame ready / swap permitted (one-cycle pulse at frame end)
//   row, column, plane   - frame buffer fetch address
//   row_out              - panel row address, only changes while oe is low
//   oclk, lat, oe        - panel shift clock, latch pulse, output enable (high = lit)
module display_driver_bcm
    import display_pkg::*;
#(
    parameter int rows         = 8,
    parameter int columns      = 32,
    parameter int bitdepth     = 8,
    parameter int pipe_latency = 3,
    localparam int row_w       = rows > 1 ? $clog2(rows) : 1,
    localparam int col_w       = columns > 1 ? $clog2(columns) : 1,
    localparam int plane_w     = bitdepth > 1 ? $clog2(bitdepth) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         brightness,
    input  logic               flip_req,
    output logic               flip_ack,
    output logic [row_w-1:0]   row,
    output logic [col_w-1:0]   column,
    output logic [plane_w-1:0] plane,
    output logic [row_w-1:0]   row_out,
    output logic               oclk,
    output logic               lat,
    output logic               oe
);

    localparam int timer_w   = 8 + bitdepth;
    localparam int pf_cycles = pipe_latency > 1 ? pipe_latency - 1 : 1;
    localparam int pf_w      = $clog2(pf_cycles + 1);

    state_t             r_state;
    logic [row_w-1:0]   r_row;
    logic [row_w-1:0]   r_row_out;
    logic [col_w-1:0]   r_column;
    logic [plane_w-1:0] r_plane;
    logic [pf_w-1:0]    r_wait;
    logic               w_timer_zero;
    logic               w_last_plane;
    logic               w_last_row;
    logic               w_last_col;
    logic [timer_w-1:0] w_on_time;

    assign w_last_plane = r_plane == plane_w'(bitdepth - 1);
    assign w_last_row   = r_row == row_w'(rows - 1);
    assign w_last_col   = r_column == col_w'(columns - 1);
    assign w_on_time    = timer_w'(plane_on_time(brightness, 32'(r_plane)));

    bcm_on_timer #(.width(timer_w)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (r_state == LATCH),
        .i_value (w_on_time),
        .o_zero  (w_timer_zero)
    );

    // LATCH is only reached once the timer has drained, so oe is low there and in the guard cycle.
    assign oe       = !w_timer_zero;
    assign oclk     = r_state == SHIFT_HI;
    assign lat      = r_state == LATCH;
    assign flip_ack = r_state == FRAME_END && flip_req;
    assign row      = r_row;
    assign column   = r_column;
    assign plane    = r_plane;
    assign row_out  = r_row_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_row_out <= '0;
            r_column  <= '0;
            r_plane   <= '0;
            r_wait    <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= PREFETCH;
                PREFETCH: begin
                    r_wait  <= r_wait == pf_w'(pf_cycles - 1) ? '0 : r_wait + pf_w'(1);
                    r_state <= r_wait == pf_w'(pf_cycles - 1) ? SHIFT_LO : PREFETCH;
                end
                SHIFT_LO: begin
                    r_column <= w_last_col ? '0 : r_column + col_w'(1);
                    r_state  <= SHIFT_HI;
                end
                // Column has wrapped to 0 only after the last column was clocked out.
                SHIFT_HI: r_state <= r_column == '0 ? WAIT_LAT : SHIFT_LO;
                WAIT_LAT: begin
                    if (w_timer_zero) begin
                        r_state <= LATCH;
                        // Row address moves in the dark cycle before a new row's first plane is shown.
                        if (r_plane == '0)
                            r_row_out <= r_row;
                    end
                end
                LATCH: begin
                    r_state <= w_last_plane && w_last_row ? FRAME_END : PREFETCH;
                    if (!(w_last_plane && w_last_row)) begin
                        r_plane <= w_last_plane ? '0 : r_plane + plane_w'(1);
                        r_row   <= w_last_plane ? r_row + row_w'(1) : r_row;
                    end
                end
                FRAME_END: begin
                    r_row    <= '0;
                    r_plane  <= '0;
                    r_column <= '0;
                    r_state  <= PREFETCH;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_driver_bcm.sv
// tb_display_driver_bcm: randomized self-checking bench for display_driver_bcm against an event-level model.
module tb_display_driver_bcm;

    localparam int A_ROWS = 2;
    localparam int A_COLS = 4;
    localparam int A_BD   = 3;
    localparam int A_LPF  = A_ROWS * A_BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_b = 1'b1;
    logic [7:0] brightness = 8'd1;
    logic [7:0] brightness_b = 8'd255;
    logic       flip_req = 1'b0;
    logic       flip_req_b = 1'b0;

    logic       flip_ack, oclk, lat, oe;
    logic [0:0] row, row_out;
    logic [1:0] column, plane;

    logic       flip_ack_b, oclk_b, lat_b, oe_b;
    logic [0:0] row_b, row_out_b;
    logic [1:0] column_b;
    logic [2:0] plane_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_driver_bcm #(.rows(A_ROWS), .columns(A_COLS), .bitdepth(A_BD), .pipe_latency(3)) dut_a (
        .clk(clk), .rst(rst), .brightness(brightness), .flip_req(flip_req), .flip_ack(flip_ack),
        .row(row), .column(column), .plane(plane), .row_out(row_out), .oclk(oclk), .lat(lat), .oe(oe)
    );

    display_driver_bcm #(.rows(2), .columns(4), .bitdepth(8), .pipe_latency(3)) dut_b (
        .clk(clk), .rst(rst_b), .brightness(brightness_b), .flip_req(flip_req_b), .flip_ack(flip_ack_b),
        .row(row_b), .column(column_b), .plane(plane_b), .row_out(row_out_b), .oclk(oclk_b), .lat(lat_b), .oe(oe_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model of the small panel: the k-th latch since reset carries row (k/bitdepth)%rows, plane k%bitdepth;
    // the lit time after it is brightness-at-latch * 2^plane; a frame is rows*bitdepth latches.
    int a_k = 0, a_oclk_n = 0, a_run = 0, a_acks = 0, a_b = 0, a_p = 0;
    int a_v_ovl = 0, a_v_latoe = 0, a_v_ro = 0, a_v_addr = 0, a_v_col = 0, a_overlap = 0;
    logic [0:0] a_prev_ro = '0;
    logic [1:0] a_prev_col = '0;

    always @(negedge clk) begin
        if (rst) begin
            a_k = 0; a_oclk_n = 0; a_run = 0; a_acks = 0; a_b = 0; a_p = 0;
        end else begin
            if (oclk && lat) a_v_ovl++;
            if (lat && oe) a_v_latoe++;
            if (row_out != a_prev_ro && oe) a_v_ro++;
            if (oe && oclk) a_overlap++;
            if (oe) a_run++;
            if (flip_ack) a_acks++;
            if (oclk) begin
                if (int'(a_prev_col) != a_oclk_n) a_v_col++;
                if (int'(row) != (a_k / A_BD) % A_ROWS || int'(plane) != a_k % A_BD) a_v_addr++;
                a_oclk_n++;
            end
            if (lat) begin
                if (a_k > 0) check("a_oe_run", a_run, a_b << a_p);
                check("a_oclk_per_lat", a_oclk_n, A_COLS);
                if (a_k % A_BD == 0) check("a_row_out", row_out, (a_k / A_BD) % A_ROWS);
                if (a_k > 0 && a_k % A_LPF == 0) check("a_flip_ack_frame_end", a_acks, flip_req);
                else check("a_flip_ack_mid", a_acks, 0);
                a_b = int'(brightness);
                a_p = a_k % A_BD;
                a_k++;
                a_run = 0; a_oclk_n = 0; a_acks = 0;
            end
        end
        a_prev_ro = row_out;
        a_prev_col = column;
    end

    // Large-depth panel at full brightness: runs of 255 * 2^plane for row 0.
    int b_k = 0, b_run = 0, b_v = 0, b_acks = 0, b_oclk_n = 0;
    logic [0:0] b_prev_ro = '0;
    logic [1:0] b_prev_col = '0;

    always @(negedge clk) begin
        if (rst_b) begin
            b_k = 0; b_run = 0; b_oclk_n = 0;
        end else begin
            if (oe_b) b_run++;
            if (flip_ack_b) b_acks++;
            if ((row_out_b != b_prev_ro && oe_b) || (lat_b && oe_b) || (lat_b && oclk_b)) b_v++;
            if (oclk_b) begin
                if (int'(b_prev_col) != b_oclk_n || int'(plane_b) != b_k % 8 || int'(row_b) != (b_k / 8) % 2) b_v++;
                b_oclk_n++;
            end
            if (lat_b) begin
                if (b_k == 8) check("b_plane7_run", b_run, 32640);
                else if (b_k > 0 && b_k < 8) check("b_oe_run", b_run, 255 << (b_k - 1));
                if (b_k == 8) check("b_row_out_row1", row_out_b, 1);
                b_k++;
                b_run = 0; b_oclk_n = 0;
            end
        end
        b_prev_ro = row_out_b;
        b_prev_col = column_b;
    end

    task automatic wait_lats(input int t);
        for (int c = 0; c < 6000 && a_k < t; c++) @(posedge clk);
        check("a_lat_wait", a_k >= t, 1);
        #1;
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not complete, a_lats %0d b_lats %0d", a_k, b_k);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_oe", oe, 0);
        check("rst_lat", lat, 0);
        check("rst_oclk", oclk, 0);
        check("rst_flip_ack", flip_ack, 0);
        check("rst_row", row, 0);
        check("rst_row_out", row_out, 0);
        check("rst_column", column, 0);
        check("rst_plane", plane, 0);
        rst = 1'b0;
        rst_b = 1'b0;

        wait_lats(A_LPF);
        brightness = 8'd0;
        wait_lats(A_LPF + 1);
        flip_req = 1'b1;
        wait_lats(2 * A_LPF);

        for (int f = 2; f < 8; f++) begin
            wait_lats(A_LPF * f + 1);
            flip_req = 1'b0;
            brightness = (f == 3) ? 8'd0 : 8'($urandom_range(0, 255));
            wait_lats(A_LPF * f + 3);
            flip_req = 1'($urandom_range(0, 1));
            wait_lats(A_LPF * f + A_LPF);
        end

        brightness = 8'd37;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (oclk && row == 1'b1 && plane == 2'd2) break;
        end
        check("a_rst_target_found", oclk && row == 1'b1 && plane == 2'd2, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_oe", oe, 0);
        check("midrst_lat", lat, 0);
        check("midrst_oclk", oclk, 0);
        check("midrst_flip_ack", flip_ack, 0);
        check("midrst_row", row, 0);
        check("midrst_row_out", row_out, 0);
        check("midrst_column", column, 0);
        check("midrst_plane", plane, 0);
        #1 rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (oclk) break;
        end
        check("after_rst_first_shift", oclk, 1);
        check("after_rst_row", row, 0);
        check("after_rst_plane", plane, 0);
        wait_lats(A_LPF + 1);

        for (int c = 0; c < 80000 && b_k < 9; c++) @(posedge clk);
        check("b_lat_reached", b_k >= 9, 1);

        check("a_oclk_lat_overlap", a_v_ovl, 0);
        check("a_lat_while_oe", a_v_latoe, 0);
        check("a_row_out_while_oe", a_v_ro, 0);
        check("a_fetch_row_plane", a_v_addr, 0);
        check("a_fetch_column", a_v_col, 0);
        check("a_shift_display_overlap", a_overlap > 0, 1);
        check("b_invariants", b_v, 0);
        check("b_flip_ack_without_req", b_acks, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_driver_bcm.md
DISPLAY_DRIVER_BCM -- requirements
Module: display_driver_bcm

Interface
REQ-001 SHALL parameter rows, default 8, number of addressable panel rows.
REQ-002 SHALL parameter columns, default 32, shift-register bits per line.
REQ-003 SHALL parameter bitdepth, default 8, number of bit planes per pixel.
REQ-004 SHALL parameter pipe_latency, default 3, cycles from fetch address to valid encoded pixel data.
REQ-005 SHALL use one clock and a synchronous, active-high reset: port clk (rising edge), then port rst.
REQ-006 SHALL have port clk  input  1  system clock.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port brightness  input  8  global on-time multiplier, sampled at each lat pulse.
REQ-009 SHALL have port flip_req  input  1  level; a new frame buffer is ready.
REQ-010 SHALL have port flip_ack  output  1  one-cycle pulse; buffer swap permitted this cycle.
REQ-011 SHALL have ports row, column, plane  output  clog2(rows)/clog2(columns)/clog2(bitdepth)  fetch address to frame buffer.
REQ-012 SHALL have port row_out  output  clog2(rows)  panel A address, changes only while oe=0.
REQ-013 SHALL have ports oclk, lat, oe  output  1  panel shift clock, latch pulse, output enable (high = lit).

Function
REQ-014 SHALL use binary-coded modulation: plane p is displayed for brightness*2^p cycles; oe_timer width 8+bitdepth bits, no overflow.
REQ-015 SHALL sequence fetch order row-major: for each row, planes 0..bitdepth-1, columns 0..columns-1 per plane.
REQ-016 SHALL implement states IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, WAIT_LAT, LATCH, FRAME_END.
REQ-017 IDLE: one cycle after reset, then PREFETCH.
REQ-018 PREFETCH: issue column 0 address, wait pipe_latency-1 cycles, then SHIFT_LO.
REQ-019 SHIFT_LO (oclk=0) / SHIFT_HI (oclk=1) alternate: one cycle each per column; column advances on entry to SHIFT_HI; after last column's SHIFT_HI -> WAIT_LAT.
REQ-020 Shifting plane n+1 SHALL overlap display (oe high) of plane n.
REQ-021 WAIT_LAT: hold until oe_timer==0, oe forced low for >=1 guard cycle, then LATCH.
REQ-022 LATCH: lat=1 one cycle; oe_timer loaded with brightness<<latched_plane; if latched plane is 0, row_out updates to latched row in the same cycle.
REQ-023 oe SHALL be high exactly while oe_timer!=0 and state is not WAIT_LAT guard or LATCH; timer decrements each cycle oe is high.
REQ-024 After LATCH: if more planes/rows remain -> PREFETCH for next address; after last plane of last row -> FRAME_END.
REQ-025 FRAME_END: one cycle; row/plane/column wrap to 0; if flip_req=1, flip_ack=1 this cycle only; then PREFETCH.
REQ-026 flip_ack SHALL never assert outside FRAME_END; flip_req high mid-frame SHALL be deferred to next FRAME_END.
REQ-027 brightness=0 SHALL keep oe low permanently while lat/oclk sequencing continues unchanged.
REQ-028 oclk and lat SHALL never be high in the same cycle; lat SHALL never be high while oe is high.

Reset
REQ-029 On rst=1: oe, lat, oclk, flip_ack=0; row, row_out, column, plane, oe_timer=0; state=IDLE, effective next cycle.
REQ-030 Reset asserted mid-shift or mid-display SHALL abort immediately; no partial lat pulse.

Structure
REQ-031 State encodings and the plane on-time function SHALL live in shared package display_pkg.
REQ-032 The oe_timer (load, decrement, zero flag) SHALL be sub-module bcm_on_timer.

Verification
REQ-033 rows=2, columns=4, bitdepth=3, pipe_latency=3, brightness=1: oe high runs of 1,2,4 cycles per row; 4 oclk pulses between lat pulses; 6 lat per frame.
REQ-034 Same config, brightness=0: oe never high; lat count per frame still 6; flip_ack on each FRAME_END with flip_req=1.
REQ-035 flip_req raised mid-frame: flip_ack exactly one cycle at next FRAME_END, none earlier; flip_req low -> no flip_ack.
REQ-036 brightness=255, bitdepth=8: plane 7 oe run = 32640 cycles; no timer wrap; row_out changes only with oe=0.
REQ-037 rst pulsed during SHIFT_HI of row 1 plane 2: next cycle all outputs 0, IDLE; following frame starts at row 0 plane 0.
